load_store_unit: RTL

Sub-word load/store sequencer between the EX/MEM pipeline register and the word-only, 1024-entry data memory. It supports byte, halfword and word accesses, with sign or zero extension on loads. Sub-word stores are done as read-modify-write because the memory writes whole words only. Its registered read takes one cycle, and it drives `busy` back to the pipeline as a stall until the access completes.

---
 rtl/load_store_unit.sv | 116 +++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word load-store sequencer in front of a word-only data memory.
// Sub-word stores are done as read-modify-write.
module load_store_unit #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, RSP, WR} state_t;
  state_t state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [1:0] off_q, off_d, size_q, size_d;
  logic uns_q, uns_d, write_q, write_d, rv_q, rv_d, mis_q, mis_d;
  logic [15:0] wdat_q, wdat_d, lane;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d, ext, mask, merged;
  logic bad, word_st;
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_BITS+2];
  always_comb begin
    bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    word_st = req_write && req_size == 2'b10;
    lane = 16'(mem_rdata >> {off_q, 3'b000});
    ext = size_q == 2'b00 ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
          size_q == 2'b01 ? {{16{~uns_q & lane[15]}}, lane} : mem_rdata;
    // bits of wdat_q beyond the addressed lane(s) are shifted out or masked off
    mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << {off_q, 3'b000};
    merged = (mem_rdata & ~mask) | (({16'b0, wdat_q} << {off_q, 3'b000}) & mask);
    state_d = state_q;
    addr_d = addr_q;
    off_d = off_q;
    size_d = size_q;
    uns_d = uns_q;
    write_d = write_q;
    wdat_d = wdat_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rv_d = 1'b0;
    mis_d = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        mis_d = bad;
        if (!bad) begin
          addr_d = req_addr[ADDR_BITS+1:2];
          off_d = req_addr[1:0];
          size_d = req_size;
          uns_d = req_unsigned;
          write_d = req_write;
          wdat_d = req_wdata[15:0];
          wdata_d = word_st ? req_wdata : wdata_q;
          state_d = word_st ? WR : RD;
        end
      end
      RD: state_d = RSP;
      RSP: begin
        state_d = write_q ? WR : IDLE;
        wdata_d = write_q ? merged : wdata_q;
        rdata_d = write_q ? rdata_q : ext;
        rv_d = !write_q;
      end
      default: begin
        state_d = IDLE;
        rdata_d = '0;
        rv_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      off_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      write_q <= 1'b0;
      wdat_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rv_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      off_q <= off_d;
      size_q <= size_d;
      uns_q <= uns_d;
      write_q <= write_d;
      wdat_q <= wdat_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rv_q <= rv_d;
      mis_q <= mis_d;
    end
  assign busy = state_q != IDLE;
  assign mem_read = state_q == RD;
  assign mem_write = state_q == WR;
  assign resp_valid = rv_q;
  assign misalign = mis_q;
  assign resp_rdata = rdata_q;
  assign mem_wdata = wdata_q;
  assign mem_addr = {{(32-ADDR_BITS){1'b0}}, addr_q};
endmodule
